// File: rtl/ay_regs.sv
// ay_regs: bus-facing register file and master-clock prescaler for the
// AY-3-891x core. Decodes the BDIR/BC1 bus, holds the sixteen PSG
// registers (masked to their architectural widths) and produces the /16
// and /256 tick enables for the tone, noise and envelope stages.
module ay_regs #(
  parameter logic [3:0] A_HI = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        bdir,
  input  logic        bc1,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic [11:0] tone_period_a,
  output logic [11:0] tone_period_b,
  output logic [11:0] tone_period_c,
  output logic [4:0]  noise_period,
  output logic [7:0]  mixer,
  output logic [4:0]  amp_a,
  output logic [4:0]  amp_b,
  output logic [4:0]  amp_c,
  output logic [15:0] env_period,
  output logic [3:0]  env_shape,
  output logic        shape_tick,
  output logic        tick16,
  output logic        tick256
);

  // Bus modes as {bdir, bc1}
  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;
  localparam logic [1:0] MODE_LATCH = 2'b11;

  // Register holding the envelope shape; writing it restarts the envelope.
  localparam logic [3:0] ENV_SHAPE_ADDR = 4'd13;

  // Architectural width of each PSG register, expressed as a bit mask.
  // Bits outside the mask are never stored, so they always read back as 0.
  function automatic logic [7:0] reg_mask(input int idx);
    case (idx)
      1, 3, 5, 13: return 8'h0F;
      6, 8, 9, 10: return 8'h1F;
      default:     return 8'hFF;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Bus protocol state
  // ---------------------------------------------------------------------
  logic [1:0] mode;
  logic [1:0] mode_prev_reg;
  logic       mode_edge;
  logic       latch_fire;
  logic       write_fire;
  logic       read_active;

  logic [3:0] addr_reg;
  logic       sel_reg;

  // Register storage, one 8-bit word per PSG register
  logic [7:0] regs_q [16];

  // Read port
  logic [7:0] d_out_reg;
  logic       d_oe_reg;

  // Envelope restart strobe
  logic       shape_tick_reg;

  // Prescaler
  logic [7:0] pre_reg;
  logic [7:0] pre_next;
  logic       tick16_reg;
  logic       tick16_next;
  logic       tick256_reg;
  logic       tick256_next;

  // Decode the bus mode; latch and write act only on the first cycle of a
  // new mode, so a strobe held for many clocks performs a single action.
  always_comb begin
    mode        = {bdir, bc1};
    mode_edge   = (mode != mode_prev_reg);
    latch_fire  = mode_edge && (mode == MODE_LATCH);
    write_fire  = mode_edge && (mode == MODE_WRITE) && sel_reg;
    read_active = (mode == MODE_READ);
  end

  // Track the previous bus mode and the latched address / chip select.
  // After reset the previous mode is idle, so a strobe still held across
  // reset release is treated as a fresh transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_prev_reg <= MODE_IDLE;
      addr_reg      <= 4'h0;
      sel_reg       <= (A_HI == 4'h0);
    end else begin
      mode_prev_reg <= mode;
      if (latch_fire) begin
        addr_reg <= d_in[3:0];
        sel_reg  <= (d_in[7:4] == A_HI);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Register file: one masked storage word per register
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_reg
      localparam logic [7:0] MASK = reg_mask(gi);

      logic       wr_en;
      logic [7:0] r_reg;

      assign wr_en = write_fire && (addr_reg == 4'(gi));

      // Store the write data trimmed to this register's width
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_reg <= 8'h00;
        end else if (wr_en) begin
          r_reg <= d_in & MASK;
        end
      end

      assign regs_q[gi] = r_reg;
    end
  endgenerate

  // Read port: refreshed every cycle the bus stays in read mode so that a
  // register change during a long read is visible; d_out holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out_reg <= 8'h00;
      d_oe_reg  <= 1'b0;
    end else if (read_active) begin
      if (sel_reg) begin
        d_out_reg <= regs_q[addr_reg];
        d_oe_reg  <= 1'b1;
      end else begin
        d_out_reg <= 8'hFF;
        d_oe_reg  <= 1'b0;
      end
    end else begin
      d_oe_reg <= 1'b0;
    end
  end

  // Pulse shape_tick for any accepted R13 write, even of an unchanged
  // value; it lines up with the new env_shape in the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shape_tick_reg <= 1'b0;
    end else begin
      shape_tick_reg <= write_fire && (addr_reg == ENV_SHAPE_ADDR);
    end
  end

  // ---------------------------------------------------------------------
  // Prescaler: free-running 8-bit count of master-clock enables
  // ---------------------------------------------------------------------

  // Next count and tick decodes, taken from the count before increment
  always_comb begin
    pre_next     = pre_reg;
    tick16_next  = 1'b0;
    tick256_next = 1'b0;
    if (clk_en) begin
      pre_next     = pre_reg + 8'd1;
      tick16_next  = (pre_reg[3:0] == 4'hF);
      tick256_next = (pre_reg == 8'hFF);
    end
  end

  // Prescaler count and single-cycle tick pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_reg     <= 8'h00;
      tick16_reg  <= 1'b0;
      tick256_reg <= 1'b0;
    end else begin
      pre_reg     <= pre_next;
      tick16_reg  <= tick16_next;
      tick256_reg <= tick256_next;
    end
  end

  // ---------------------------------------------------------------------
  // Output decodes straight from storage
  // ---------------------------------------------------------------------
  assign d_out         = d_out_reg;
  assign d_oe          = d_oe_reg;
  assign tone_period_a = {regs_q[1][3:0], regs_q[0]};
  assign tone_period_b = {regs_q[3][3:0], regs_q[2]};
  assign tone_period_c = {regs_q[5][3:0], regs_q[4]};
  assign noise_period  = regs_q[6][4:0];
  assign mixer         = regs_q[7];
  assign amp_a         = regs_q[8][4:0];
  assign amp_b         = regs_q[9][4:0];
  assign amp_c         = regs_q[10][4:0];
  assign env_period    = {regs_q[12], regs_q[11]};
  // Bit order: [3] cont, [2] attack, [1] alt, [0] hold
  assign env_shape     = regs_q[13][3:0];
  assign shape_tick    = shape_tick_reg;
  assign tick16        = tick16_reg;
  assign tick256       = tick256_reg;

endmodule

// File: tb/tb_ay_regs.sv
// tb_ay_regs: scoreboard bench for ay_regs. Expected values come from a
// small register model and are queued when stimulus is driven, then popped
// and compared when the DUT output is sampled (1 time unit after the edge).
module tb_ay_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        bdir;
  logic        bc1;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [11:0] tone_period_a;
  logic [11:0] tone_period_b;
  logic [11:0] tone_period_c;
  logic [4:0]  noise_period;
  logic [7:0]  mixer;
  logic [4:0]  amp_a;
  logic [4:0]  amp_b;
  logic [4:0]  amp_c;
  logic [15:0] env_period;
  logic [3:0]  env_shape;
  logic        shape_tick;
  logic        tick16;
  logic        tick256;

  ay_regs dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .bdir         (bdir),
    .bc1          (bc1),
    .d_in         (d_in),
    .d_out        (d_out),
    .d_oe         (d_oe),
    .tone_period_a(tone_period_a),
    .tone_period_b(tone_period_b),
    .tone_period_c(tone_period_c),
    .noise_period (noise_period),
    .mixer        (mixer),
    .amp_a        (amp_a),
    .amp_b        (amp_b),
    .amp_c        (amp_c),
    .env_period   (env_period),
    .env_shape    (env_shape),
    .shape_tick   (shape_tick),
    .tick16       (tick16),
    .tick256      (tick256)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard queues
  string       tag_q [$];
  logic [31:0] exp_q [$];

  // Reference model of the register file
  logic [7:0] mdl_regs [16];
  logic [3:0] mdl_addr;
  logic       mdl_sel;

  function automatic logic [7:0] mdl_mask(input logic [3:0] idx);
    case (idx)
      4'd1, 4'd3, 4'd5, 4'd13: return 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: return 8'h1F;
      default:                 return 8'hFF;
    endcase
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl_regs[i] = 8'h00;
    mdl_addr = 4'h0;
    mdl_sel  = 1'b1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  task automatic sb_expect(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_compare(input logic [31:0] got);
    string       tag;
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      check_val(tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare every register decode output against the model
  task automatic check_outputs(input string tag);
    sb_expect({tag, "_tone_a"}, 32'({mdl_regs[1][3:0], mdl_regs[0]}));
    sb_expect({tag, "_tone_b"}, 32'({mdl_regs[3][3:0], mdl_regs[2]}));
    sb_expect({tag, "_tone_c"}, 32'({mdl_regs[5][3:0], mdl_regs[4]}));
    sb_expect({tag, "_noise"},  32'(mdl_regs[6][4:0]));
    sb_expect({tag, "_mixer"},  32'(mdl_regs[7]));
    sb_expect({tag, "_amp_a"},  32'(mdl_regs[8][4:0]));
    sb_expect({tag, "_amp_b"},  32'(mdl_regs[9][4:0]));
    sb_expect({tag, "_amp_c"},  32'(mdl_regs[10][4:0]));
    sb_expect({tag, "_envp"},   32'({mdl_regs[12], mdl_regs[11]}));
    sb_expect({tag, "_shape"},  32'(mdl_regs[13][3:0]));
    sb_compare(32'(tone_period_a));
    sb_compare(32'(tone_period_b));
    sb_compare(32'(tone_period_c));
    sb_compare(32'(noise_period));
    sb_compare(32'(mixer));
    sb_compare(32'(amp_a));
    sb_compare(32'(amp_b));
    sb_compare(32'(amp_c));
    sb_compare(32'(env_period));
    sb_compare(32'(env_shape));
  endtask

  task automatic bus_latch(input logic [7:0] a);
    bdir = 1'b1; bc1 = 1'b1; d_in = a;
    mdl_addr = a[3:0];
    mdl_sel  = (a[7:4] == 4'h0);
    step();
    bdir = 1'b0; bc1 = 1'b0;
    step();
  endtask

  // Write strobe held n cycles; shape_tick checked every cycle
  task automatic bus_write(input string tag, input logic [7:0] d, input int n);
    logic tick_exp;
    tick_exp = mdl_sel && (mdl_addr == 4'd13);
    bdir = 1'b1; bc1 = 1'b0; d_in = d;
    if (mdl_sel) mdl_regs[mdl_addr] = d & mdl_mask(mdl_addr);
    for (int c = 0; c < n; c++) begin
      sb_expect($sformatf("%s_stick%0d", tag, c), 32'((c == 0) && tick_exp));
      step();
      sb_compare(32'(shape_tick));
    end
    bdir = 1'b0;
    sb_expect({tag, "_stick_idle"}, 32'd0);
    step();
    sb_compare(32'(shape_tick));
  endtask

  // Latch followed directly by a write with no idle cycle between
  task automatic bus_latch_write(input string tag, input logic [7:0] a, input logic [7:0] d);
    bdir = 1'b1; bc1 = 1'b1; d_in = a;
    mdl_addr = a[3:0];
    mdl_sel  = (a[7:4] == 4'h0);
    step();
    bc1 = 1'b0; d_in = d;
    if (mdl_sel) mdl_regs[mdl_addr] = d & mdl_mask(mdl_addr);
    step();
    bdir = 1'b0;
    step();
    check_outputs(tag);
  endtask

  // Read held two cycles, then leave read mode
  task automatic bus_read(input string tag);
    logic [7:0] dexp;
    dexp = mdl_sel ? mdl_regs[mdl_addr] : 8'hFF;
    bdir = 1'b0; bc1 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sb_expect($sformatf("%s_dout%0d", tag, c), 32'(dexp));
      sb_expect($sformatf("%s_doe%0d", tag, c), 32'(mdl_sel));
      step();
      sb_compare(32'(d_out));
      sb_compare(32'(d_oe));
    end
    bc1 = 1'b0;
    sb_expect({tag, "_doe_off"}, 32'd0);
    sb_expect({tag, "_dout_hold"}, 32'(dexp));
    step();
    sb_compare(32'(d_oe));
    sb_compare(32'(d_out));
  endtask

  initial begin
    int n16;
    int n256;
    int lone256;
    logic [7:0] rv;

    reset = 1'b1; clk_en = 1'b0; bdir = 1'b0; bc1 = 1'b0; d_in = 8'h00;
    mdl_reset();
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    sb_expect("rst_dout", 32'h00);
    sb_expect("rst_doe", 32'd0);
    sb_expect("rst_stick", 32'd0);
    sb_expect("rst_t16", 32'd0);
    sb_expect("rst_t256", 32'd0);
    sb_compare(32'(d_out));
    sb_compare(32'(d_oe));
    sb_compare(32'(shape_tick));
    sb_compare(32'(tick16));
    sb_compare(32'(tick256));
    check_outputs("rst");

    // Read with the reset address/select, then every register
    bus_read("rd_reset_addr");
    for (int i = 0; i < 16; i++) begin
      bus_latch(8'(i));
      bus_read($sformatf("rd0_r%0d", i));
    end

    // Masking of R1 and R8
    bus_latch(8'h01);
    bus_write("w_r1", 8'hFF, 1);
    bus_read("rd_r1");
    check_outputs("after_r1");
    bus_latch(8'h08);
    bus_write("w_r8", 8'hFF, 1);
    check_outputs("after_r8");

    // R13 held write, rewrite, back-to-back
    bus_latch(8'h0D);
    bus_write("w_r13_hold", 8'hAE, 5);
    check_outputs("after_r13");
    bus_write("w_r13_again", 8'hAE, 1);
    bus_write("w_r13_b2b", 8'h09, 1);
    check_outputs("after_r13_b2b");

    // Latch directly into write uses the new address
    bus_latch_write("lw_r7", 8'h07, 8'h3C);

    // Wrong chip select: writes ignored, read gives FF / not driven
    bus_latch(8'h37);
    bus_write("w_nosel", 8'h55, 1);
    check_outputs("after_nosel");
    bus_read("rd_nosel");

    // Random sweep of all registers
    for (int i = 0; i < 16; i++) begin
      bus_latch(8'(i));
      rv = 8'($urandom_range(0, 255));
      bus_write($sformatf("w_sweep_r%0d", i), rv, 1);
    end
    check_outputs("sweep");
    for (int i = 0; i < 16; i++) begin
      bus_latch(8'(i));
      bus_read($sformatf("rd_sweep_r%0d", i));
    end

    // Prescaler with clk_en held high for 512 cycles
    n16 = 0; n256 = 0; lone256 = 0;
    clk_en = 1'b1;
    for (int k = 1; k <= 512; k++) begin
      sb_expect($sformatf("t16_k%0d", k), 32'((k % 16) == 0));
      sb_expect($sformatf("t256_k%0d", k), 32'((k % 256) == 0));
      step();
      sb_compare(32'(tick16));
      sb_compare(32'(tick256));
      if (tick16) n16++;
      if (tick256) n256++;
      if (tick256 && !tick16) lone256++;
    end
    clk_en = 1'b0;
    check_val("t16_count", 32'(n16), 32'd32);
    check_val("t256_count", 32'(n256), 32'd2);
    check_val("t256_without_t16", 32'(lone256), 32'd0);

    // Sparse clk_en: tick16 after the 16th enable, one clk wide
    for (int p = 1; p <= 16; p++) begin
      clk_en = 1'b1;
      sb_expect($sformatf("sparse_t16_p%0d", p), 32'(p == 16));
      step();
      sb_compare(32'(tick16));
      clk_en = 1'b0;
      sb_expect($sformatf("sparse_t16_gap%0d", p), 32'd0);
      step();
      sb_compare(32'(tick16));
    end

    // Reset asserted in the middle of a held write
    bus_latch(8'h0B);
    bus_write("w_r11", 8'h34, 1);
    bus_latch(8'h0C);
    bus_write("w_r12", 8'h12, 1);
    sb_expect("envp_pre_reset", 32'h1234);
    sb_compare(32'(env_period));
    bus_latch(8'h05);
    bdir = 1'b1; bc1 = 1'b0; d_in = 8'h5A;
    mdl_regs[5] = 8'h5A & mdl_mask(4'd5);
    step();
    #2 reset = 1'b1;
    #1;
    mdl_reset();
    sb_expect("rst_mid_d_oe", 32'd0);
    sb_compare(32'(d_oe));
    check_outputs("rst_mid");
    step();
    step();
    reset = 1'b0;
    mdl_regs[0] = 8'h5A;
    step();
    check_outputs("post_rst_write");
    d_in = 8'h77;
    repeat (3) step();
    check_outputs("post_rst_held");
    bdir = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ay_regs.md
# ay_regs

Bus-facing register file and clock prescaler for the AY-3-891x core. It decodes the BDIR/BC1 bus protocol, holds the sixteen PSG registers, and masks each one to its architectural width. It also generates the /16 and /256 tick enables that drive the tone, noise and envelope stages. It sits directly upstream of the envelope generator and feeds it `env_period`, `env_shape`, `shape_tick` and `tick256`.

## Interface
- `A_HI`, default 4'h0: required upper address nibble (chip select) for address latch cycles.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `clk_en`  input  1  one-cycle pulse per PSG master clock.
- `bdir`  input  1  bus direction; synchronous to `clk`.
- `bc1`  input  1  bus control; synchronous to `clk`.
- `d_in`  input  8  CPU write/address data.
- `d_out`  output  8  read data, registered.
- `d_oe`  output  1  read data valid / drive enable.
- `tone_period_a`, `tone_period_b`, `tone_period_c`  output  12 each  {R1[3:0],R0}, {R3[3:0],R2}, {R5[3:0],R4}.
- `noise_period`  output  5  R6[4:0].
- `mixer`  output  8  R7.
- `amp_a`, `amp_b`, `amp_c`  output  5 each  R8[4:0], R9[4:0], R10[4:0].
- `env_period`  output  16  {R12,R11}.
- `env_shape`  output  4  R13[3:0], in the order cont, attack, alt, hold.
- `shape_tick`  output  1  one-cycle pulse after any R13 write.
- `tick16`  output  1  one-cycle pulse every 16 `clk_en`.
- `tick256`  output  1  one-cycle pulse every 256 `clk_en`.

## Operation
- Bus mode is {bdir,bc1}: 00 inactive, 01 read, 10 write, 11 latch address.
- The previous mode is registered each clk. An action fires only on the first cycle a mode is sampled that differs from the previous cycle's mode. A strobe held for N cycles performs exactly one action.
- Latch address: `addr <= d_in[3:0]`; `sel <= (d_in[7:4] == A_HI)`.
- Write with `sel=1`: store `d_in` masked to register width into `regs[addr]`.
  - Masks: R1/R3/R5/R13 = 4'hF; R6/R8/R9/R10 = 5'h1F; all others are full 8 bits.
  - Masked-off bits read as 0.
  - Write with `sel=0`: ignored.
- Writing R13 asserts `shape_tick`. This holds for any write, including rewriting the same value, which restarts the envelope.
- Read with `sel=1`: `d_out <= regs[addr]` (masked); `d_oe <= 1`.
  - Both are refreshed every cycle while mode stays 01, so a write landing mid-read is reflected.
  - Read with `sel=0`: `d_out <= 8'hFF`; `d_oe <= 0`.
- Any mode other than 01: `d_oe <= 0`; `d_out` holds its value.
- Prescaler: 8-bit counter `pre` increments on `clk_en` and wraps 255→0.
  - `tick16 <= clk_en & (pre[3:0] == 4'hF)`.
  - `tick256 <= clk_en & (pre == 8'hFF)`.
  - At the 256 boundary both ticks pulse in the same cycle.
  - `clk_en` held high continuously gives `tick16` every 16 clk.
- All register outputs are continuous decodes of storage. There is no extra latch stage.

## Timing
- Reset (async assert, sync release):
  - all sixteen registers = 0; `addr` = 0; `sel` = (A_HI == 0); previous mode = 00; `pre` = 0.
  - `d_out` = 0, `d_oe` = 0, `shape_tick` = 0, `tick16` = 0, `tick256` = 0.
- Reset asserted mid-strobe: everything clears immediately. After release, a still-held strobe counts as a new mode (previous mode = 00) and fires once.
- Write in cycle T:
  - The register output changes at T+1.
  - `shape_tick` is high in T+1 only.
  - `env_shape` is already the new value in T+1, so the envelope stage sees shape and tick together.
- Read sampled in cycle T: `d_out`/`d_oe` valid from T+1 and held while mode stays 01. `d_oe` falls in the cycle after the mode leaves 01.
- Latch in T: a write or read whose first cycle is T+1 uses the new address.
- Back-to-back R13 writes need an intervening non-write mode and give two separate `shape_tick` pulses.
- `clk_en` in T: the tick pulse appears at T+1 and lasts exactly 1 clk.

## Test plan
- Reset, then read every register → `d_out` = 8'h00 each time, `d_oe` = 1 one cycle after read entry; `tick16`/`tick256` low until the 16th `clk_en`.
- Latch 8'h01, write 8'hFF, read back → `d_out` = 8'h0F, `tone_period_a` = 12'hF00. Latch 8'h08, write 8'hFF → `amp_a` = 5'h1F.
- Latch 8'h0D, hold write for 5 cycles with `d_in` = 8'hAE → `env_shape` = 4'hE, exactly one `shape_tick` pulse at T+1. Rewrite the same value → second pulse.
- Latch 8'h37 (with A_HI = 0), write 8'h55 → no register changes. Read → `d_oe` = 0, `d_out` = 8'hFF.
- `clk_en` held high for 512 cycles → 32 `tick16` and 2 `tick256` pulses; each `tick256` coincides with a `tick16`.
- Assert `reset` mid-write after R11/R12 = 8'h34/8'h12 (`env_period` = 16'h1234) → `env_period` = 0 immediately. After release with the strobe still held, one write occurs to address 0.
